// File: rtl/mouse_pkg.sv
// Shared definitions for the mouse packet path: packet field widths, default
// screen size and the left-button state encoding.
package mouse_pkg;

    localparam int unsigned DELTA_W      = 9;
    localparam int unsigned BTN_W        = 3;
    localparam int unsigned DEF_SCREEN_W = 160;
    localparam int unsigned DEF_SCREEN_H = 120;
    // Wide enough for any on-screen position plus or minus a full-scale delta
    localparam int unsigned CALC_W       = 11;

    localparam int unsigned BTN_LEFT  = 0;
    localparam int unsigned BTN_RIGHT = 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_DRAGGING = 2'd2
    } left_state_t;

endpackage

// File: rtl/cursor_axis_clamp.sv
// One cursor axis: sensitivity scaling of a raw delta, plus the add/subtract
// and saturation that produce the next on-screen coordinate.
module cursor_axis_clamp
    import mouse_pkg::*;
#(
    parameter int unsigned EXTENT = DEF_SCREEN_W,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned SHIFT  = 0,
    parameter bit          INVERT = 1'b0
) (
    input  logic signed [DELTA_W-1:0] i_delta,
    output logic signed [DELTA_W-1:0] o_scaled,
    input  logic        [WIDTH-1:0]   i_pos,
    input  logic signed [DELTA_W-1:0] i_sdelta,
    output logic        [WIDTH-1:0]   o_next
);

    localparam logic signed [CALC_W-1:0] MAX_POS = CALC_W'(EXTENT - 1);

    logic        [DELTA_W:0]  w_mag;
    logic        [DELTA_W:0]  w_mag_sh;
    logic signed [CALC_W-1:0] w_pos_ext;
    logic signed [CALC_W-1:0] w_d_ext;
    logic signed [CALC_W-1:0] w_sum;

    // Shift the magnitude so negative deltas truncate toward zero, not -inf
    always_comb begin
        w_mag    = i_delta[DELTA_W-1] ? -{i_delta[DELTA_W-1], i_delta}
                                      : {1'b0, i_delta};
        w_mag_sh = w_mag >> SHIFT;
        o_scaled = i_delta[DELTA_W-1] ? DELTA_W'(-w_mag_sh) : DELTA_W'(w_mag_sh);
    end

    always_comb begin
        w_pos_ext = signed'({{(CALC_W-WIDTH){1'b0}}, i_pos});
        w_d_ext   = signed'({{(CALC_W-DELTA_W){i_sdelta[DELTA_W-1]}}, i_sdelta});
        w_sum     = INVERT ? (w_pos_ext - w_d_ext) : (w_pos_ext + w_d_ext);
        if (w_sum < 0)
            o_next = '0;
        else if (w_sum > MAX_POS)
            o_next = WIDTH'(EXTENT - 1);
        else
            o_next = w_sum[WIDTH-1:0];
    end

endmodule

// File: rtl/mouse_cursor_tracker.sv
// Integrates decoded PS/2 mouse packets into a clamped cursor position and
// derives click / drag events from the left button (2-cycle pipeline).
module mouse_cursor_tracker
    import mouse_pkg::*;
#(
    parameter int unsigned SCREEN_W = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H = DEF_SCREEN_H,
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned INIT_X   = 80,
    parameter int unsigned INIT_Y   = 60,
    parameter int unsigned SHIFT    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DELTA_W-1:0] delta_x,
    input  logic [DELTA_W-1:0] delta_y,
    input  logic [BTN_W-1:0]   buttons,
    input  logic               packet_ready,
    output logic [X_W-1:0]     cursor_x,
    output logic [Y_W-1:0]     cursor_y,
    output logic               cursor_update,
    output logic [BTN_W-1:0]   buttons_q,
    output logic               left_click,
    output logic               right_click,
    output logic               drag_active,
    output logic               drag_done,
    output logic [X_W-1:0]     anchor_x,
    output logic [Y_W-1:0]     anchor_y
);

    logic signed [DELTA_W-1:0] w_sdx_raw;
    logic signed [DELTA_W-1:0] w_sdy_raw;
    logic signed [DELTA_W-1:0] r_sdx;
    logic signed [DELTA_W-1:0] r_sdy;
    logic        [BTN_W-1:0]   r_btn;
    logic                      r_s1_valid;
    logic        [X_W-1:0]     w_nx;
    logic        [Y_W-1:0]     w_ny;
    left_state_t               r_state;
    left_state_t               w_state_nxt;
    logic                      w_moved;
    logic                      w_left_click_nxt;
    logic                      w_drag_done_nxt;
    logic                      w_anchor_load;

    cursor_axis_clamp #(
        .EXTENT (SCREEN_W),
        .WIDTH  (X_W),
        .SHIFT  (SHIFT),
        .INVERT (1'b0)
    ) u_clamp_x (
        .i_delta  (delta_x),
        .o_scaled (w_sdx_raw),
        .i_pos    (cursor_x),
        .i_sdelta (r_sdx),
        .o_next   (w_nx)
    );

    // PS/2 y is positive-up, screen y grows downward
    cursor_axis_clamp #(
        .EXTENT (SCREEN_H),
        .WIDTH  (Y_W),
        .SHIFT  (SHIFT),
        .INVERT (1'b1)
    ) u_clamp_y (
        .i_delta  (delta_y),
        .o_scaled (w_sdy_raw),
        .i_pos    (cursor_y),
        .i_sdelta (r_sdy),
        .o_next   (w_ny)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_sdx      <= '0;
            r_sdy      <= '0;
            r_btn      <= '0;
        end else begin
            r_s1_valid <= packet_ready;
            if (packet_ready) begin
                r_sdx <= w_sdx_raw;
                r_sdy <= w_sdy_raw;
                r_btn <= buttons;
            end
        end
    end

    assign w_moved = (r_sdx != '0) || (r_sdy != '0);

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_left_click_nxt = 1'b0;
        w_drag_done_nxt  = 1'b0;
        w_anchor_load    = 1'b0;
        if (r_s1_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_btn[BTN_LEFT]) begin
                        w_anchor_load = 1'b1;
                        w_state_nxt   = w_moved ? ST_DRAGGING : ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    if (!r_btn[BTN_LEFT]) begin
                        w_state_nxt      = ST_IDLE;
                        w_left_click_nxt = 1'b1;
                    end else if (w_moved) begin
                        w_state_nxt = ST_DRAGGING;
                    end
                end
                ST_DRAGGING: begin
                    if (!r_btn[BTN_LEFT]) begin
                        w_state_nxt     = ST_IDLE;
                        w_drag_done_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cursor_x      <= X_W'(INIT_X);
            cursor_y      <= Y_W'(INIT_Y);
            buttons_q     <= '0;
            cursor_update <= 1'b0;
            left_click    <= 1'b0;
            right_click   <= 1'b0;
            drag_done     <= 1'b0;
            drag_active   <= 1'b0;
            anchor_x      <= '0;
            anchor_y      <= '0;
        end else begin
            cursor_update <= r_s1_valid;
            left_click    <= w_left_click_nxt;
            drag_done     <= w_drag_done_nxt;
            drag_active   <= (w_state_nxt == ST_DRAGGING);
            right_click   <= r_s1_valid && r_btn[BTN_RIGHT] && !buttons_q[BTN_RIGHT];
            if (r_s1_valid) begin
                cursor_x  <= w_nx;
                cursor_y  <= w_ny;
                buttons_q <= r_btn;
            end
            if (w_anchor_load) begin
                anchor_x <= cursor_x;
                anchor_y <= cursor_y;
            end
        end
    end

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Directed bench for mouse_cursor_tracker: one instance at SHIFT=0, one at
// SHIFT=1, sharing stimulus; expected values are hand-computed constants.
module tb_mouse_cursor_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] delta_x = '0;
    logic [8:0] delta_y = '0;
    logic [2:0] buttons = '0;
    logic       packet_ready = 1'b0;

    logic [7:0] x0, ax0, x1, ax1;
    logic [6:0] y0, ay0, y1, ay1;
    logic [2:0] bq0, bq1;
    logic       upd0, lc0, rc0, da0, dd0;
    logic       upd1, lc1, rc1, da1, dd1;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    mouse_cursor_tracker #(.SHIFT(0)) u0 (
        .clk(clk), .rst(rst), .delta_x(delta_x), .delta_y(delta_y),
        .buttons(buttons), .packet_ready(packet_ready),
        .cursor_x(x0), .cursor_y(y0), .cursor_update(upd0), .buttons_q(bq0),
        .left_click(lc0), .right_click(rc0), .drag_active(da0),
        .drag_done(dd0), .anchor_x(ax0), .anchor_y(ay0)
    );

    mouse_cursor_tracker #(.SHIFT(1)) u1 (
        .clk(clk), .rst(rst), .delta_x(delta_x), .delta_y(delta_y),
        .buttons(buttons), .packet_ready(packet_ready),
        .cursor_x(x1), .cursor_y(y1), .cursor_update(upd1), .buttons_q(bq1),
        .left_click(lc1), .right_click(rc1), .drag_active(da1),
        .drag_done(dd1), .anchor_x(ax1), .anchor_y(ay1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        packet_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns at the negedge where the packet's results are visible (N+2)
    task automatic send(input logic [8:0] dx, input logic [8:0] dy, input logic [2:0] btn);
        @(negedge clk);
        delta_x = dx;
        delta_y = dy;
        buttons = btn;
        packet_ready = 1'b1;
        @(negedge clk);
        packet_ready = 1'b0;
        delta_x = '0;
        delta_y = '0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_x", x0, 80);
        check("rst_y", y0, 60);
        check("rst_upd", upd0, 0);
        check("rst_drag", da0, 0);
        check("rst_anchor_x", ax0, 0);
        check("rst_bq", bq0, 0);
        @(negedge clk);
        check("rst_upd_idle", upd0, 0);

        // Basic move
        send(9'h00A, 9'h005, 3'b000);
        check("move_x", x0, 90);
        check("move_y", y0, 55);
        check("move_upd", upd0, 1);
        @(negedge clk);
        check("move_upd_off", upd0, 0);

        // Clamping
        do_reset();
        send(9'h138, 9'h000, 3'b000);
        check("clamp_x_low", x0, 0);
        check("clamp_upd", upd0, 1);
        send(9'h0FF, 9'h000, 3'b000);
        send(9'h0FF, 9'h000, 3'b000);
        send(9'h0FF, 9'h000, 3'b000);
        check("clamp_x_high", x0, 159);
        send(9'h000, 9'h100, 3'b000);
        check("clamp_y_high", y0, 119);
        send(9'h000, 9'h07F, 3'b000);
        check("clamp_y_low", y0, 0);

        // Left click, right click, middle passthrough
        do_reset();
        send(9'h000, 9'h000, 3'b001);
        check("click_press_lc", lc0, 0);
        check("click_press_da", da0, 0);
        check("click_anchor_x", ax0, 80);
        check("click_anchor_y", ay0, 60);
        check("click_bq", bq0, 1);
        send(9'h000, 9'h000, 3'b000);
        check("click_lc", lc0, 1);
        check("click_da", da0, 0);
        @(negedge clk);
        check("click_lc_off", lc0, 0);
        send(9'h000, 9'h000, 3'b010);
        check("rclick", rc0, 1);
        send(9'h000, 9'h000, 3'b010);
        check("rclick_held", rc0, 0);
        send(9'h000, 9'h000, 3'b100);
        check("middle_bq", bq0, 4);
        check("middle_rc", rc0, 0);

        // Drag
        do_reset();
        send(9'h000, 9'h000, 3'b001);
        check("drag_press_da", da0, 0);
        send(9'h004, 9'h000, 3'b001);
        check("drag_active", da0, 1);
        check("drag_move_x", x0, 84);
        check("drag_move_lc", lc0, 0);
        send(9'h000, 9'h000, 3'b000);
        check("drag_done", dd0, 1);
        check("drag_release_da", da0, 0);
        check("drag_release_lc", lc0, 0);
        check("drag_anchor_x", ax0, 80);
        check("drag_anchor_y", ay0, 60);
        check("drag_x", x0, 84);
        check("drag_y", y0, 60);
        @(negedge clk);
        check("drag_done_off", dd0, 0);

        // Motion into a clamped edge still counts as moved
        do_reset();
        send(9'h138, 9'h000, 3'b000);
        send(9'h1F6, 9'h000, 3'b001);
        check("edge_x", x0, 0);
        check("edge_drag", da0, 1);
        check("edge_anchor_x", ax0, 0);
        send(9'h000, 9'h000, 3'b000);
        check("edge_drag_done", dd0, 1);

        // SHIFT=1 truncation toward zero
        do_reset();
        send(9'h1FD, 9'h000, 3'b000);
        check("sh_x_m3", x1, 79);
        check("sh_upd", upd1, 1);
        send(9'h1FF, 9'h000, 3'b001);
        check("sh_x_m1", x1, 79);
        check("sh_no_move_da", da1, 0);
        send(9'h000, 9'h000, 3'b000);
        check("sh_click", lc1, 1);

        // Back-to-back packets
        do_reset();
        @(negedge clk);
        delta_x = 9'h001;
        packet_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        packet_ready = 1'b0;
        delta_x = '0;
        check("b2b_x1", x0, 81);
        check("b2b_upd1", upd0, 1);
        @(negedge clk);
        check("b2b_x2", x0, 82);
        check("b2b_upd2", upd0, 1);
        @(negedge clk);
        check("b2b_upd_off", upd0, 0);

        // Reset while a packet is in flight
        do_reset();
        @(negedge clk);
        delta_x = 9'h005;
        packet_ready = 1'b1;
        @(negedge clk);
        packet_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("flight_upd", upd0, 0);
        @(negedge clk);
        check("flight_upd2", upd0, 0);
        check("flight_x", x0, 80);

        // Packet coincident with reset is ignored
        @(negedge clk);
        rst = 1'b1;
        delta_x = 9'h007;
        packet_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        packet_ready = 1'b0;
        delta_x = '0;
        @(negedge clk);
        check("rstpkt_upd", upd0, 0);
        @(negedge clk);
        check("rstpkt_upd2", upd0, 0);
        check("rstpkt_x", x0, 80);

        // Packet in the first cycle after reset is processed
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        delta_x = 9'h003;
        packet_ready = 1'b1;
        @(negedge clk);
        packet_ready = 1'b0;
        delta_x = '0;
        @(negedge clk);
        check("post_rst_upd", upd0, 1);
        check("post_rst_x", x0, 83);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
